uart_bus_bridge: RTL and testbench
==================================

# uart_bus_bridge

UART-to-bus master that turns serial command frames from a host into single transactions on the fabric's REQ/GNT/RVALID peripheral bus, then returns a status byte and, for reads, the read data. It sits directly upstream of the register-file peripheral: its bus outputs drive the peripheral's REQ/WE/BE/ADDR/WDATA inputs, and it consumes GNT/RVALID/RDATA. The serial side connects to two user IO pins.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per UART bit. 217 gives 115200 baud at 25 MHz. Legal values are 8 or more.
- BUS_TIMEOUT, default 1023: maximum number of cycles to wait for GNT, and separately for RVALID, before the transaction is aborted.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1: the single clock; all logic is on its rising edge.
- rst_n  in  1: asynchronous active-low reset.
- rx  in  1: UART receive line, 8N1, idle high. Asynchronous to clk.
- tx  out  1: UART transmit line, 8N1, idle high.
- REQ  out  1: bus request.
- WE  out  1: write enable (1 = write).
- BE  out  4: byte enables; BE[n] covers WDATA[8n+7:8n].
- ADDR  out  24: word address.
- WDATA  out  32: write data.
- GNT  in  1: request accepted.
- RVALID  in  1: response valid. RDATA is valid when RVALID = 1.
- RDATA  in  32: read data.

## Operation

**Frame format (host to bridge, bytes MSB first)**
- Command byte: bit7 = WE; bits3:0 = BE; bits6:4 are ignored.
- Then 3 address bytes, ADDR[23:16] first.
- Writes only: then 4 data bytes, WDATA[31:24] first.

**Response (bridge to host)**
- Status byte: 0xA5 = OK, 0xEE = bus timeout.
- Reads with OK status: the status byte is followed by 4 RDATA bytes, [31:24] first.

**RX path**
- rx passes through a 2-flop synchronizer.
- A falling edge starts a byte. The start bit is re-checked at mid-bit; if rx is high there, it was a glitch and reception returns to idle.
- Data bits are sampled at mid-bit, LSB first.
- If the stop bit samples 0, that is a framing error: the byte is dropped and the FSM returns to CMD.

**FSM states**
- CMD: wait for the command byte, then go to ADDR.
- ADDR: collect 3 bytes. Then go to DATA if WE, otherwise to BUS.
- DATA: collect 4 bytes, then go to BUS.
- BUS: REQ = 1, with WE/BE/ADDR/WDATA held stable. On a cycle with GNT = 1, go to RSP. If RVALID is also 1 in that same cycle, the response is taken immediately.
- RSP: wait for RVALID = 1. On RVALID, capture RDATA and set status to OK.
- TX_STAT: send the status byte. Then go to TX_DATA if this was a read with OK status, otherwise to CMD.
- TX_DATA: send the 4 captured bytes, then go to CMD.

**Rules**
- Bytes received while in BUS, RSP, TX_STAT or TX_DATA are discarded.
- A read always drives BE as received; the peripheral ignores BE on reads.
- Timeout: a counter starts at BUS entry and restarts at RSP entry. When it reaches BUS_TIMEOUT, status becomes 0xEE, REQ drops, and the FSM goes to TX_STAT. A late GNT or RVALID after this is ignored.
- Exactly one transaction is outstanding at a time.

## Timing
- Reset values: tx = 1, REQ = 0, WE = 0, BE = 0, ADDR = 0, WDATA = 0. The FSM is in CMD with counters at 0.
- Reset asserted mid-frame or mid-transaction aborts at once; no response is sent.
- REQ rises in the cycle after the stop-bit mid-sample of the last frame byte.
- REQ falls in the cycle after GNT is sampled high.
- The bus fields (WE/BE/ADDR/WDATA) keep their values after REQ falls, until the next frame's bytes overwrite them.
- Round trip when GNT and RVALID come in the same cycle: REQ high 1 cycle, then the tx start bit begins 1 cycle after RVALID.
- Bytes are sent back-to-back with no idle gap. Each byte lasts 10 × CLKS_PER_BIT cycles.
- Received bytes must arrive with the stop bit at least one bit-time long.

## Configuration
- UART_BRIDGE_FRAME_TIMEOUT_EN defined: once a frame has started, a gap of more than 16 bit-times (16 × CLKS_PER_BIT cycles) between one stop bit and the next start bit aborts the partial frame and returns the FSM to CMD. No response is sent.
- UART_BRIDGE_FRAME_TIMEOUT_EN undefined: a partial frame waits indefinitely for its remaining bytes.

## Test plan
- Write: send 0x8F, 00 00 05, DE AD BE EF. Required: REQ = 1 with WE = 1, BE = 0xF, ADDR = 0x000005, WDATA = 0xDEADBEEF. GNT and RVALID same cycle. tx returns 0xA5.
- Read: after the write above, send 0x0F, 00 00 05 to a register-file peripheral model. Required: tx returns A5 DE AD BE EF.
- Partial write then read back: send 0x81, 00 00 05, 11 22 33 44, then read. Required: write status 0xA5; the read returns A5 DE AD BE 44.
- Delayed handshake: GNT delayed 5 cycles and RVALID a further 7. Required: REQ held with stable fields for 6 cycles; RDATA captured on the RVALID cycle; correct data returned.
- Timeout: GNT tied low with BUS_TIMEOUT = 15. Required: REQ drops after 15 cycles; tx sends only 0xEE.
- Line errors:
  - A byte with stop bit = 0 in the middle of a frame: the next 0x8F is treated as a new command.
  - With UART_BRIDGE_FRAME_TIMEOUT_EN defined, a 20-bit-time gap after the address bytes: no REQ, and the next byte is parsed as a command.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
//
// Purpose:
//   UART-to-bus master. A host sends a command frame over an 8N1 serial line:
//     - command byte: bit7 = WE, bits3:0 = BE, bits6:4 ignored
//     - 3 address bytes, MSB first
//     - 4 data bytes, MSB first (writes only)
//   The bridge issues one REQ/GNT/RVALID transaction for each frame. It then
//   returns a status byte: 0xA5 for OK, 0xEE for a bus timeout. A read with OK
//   status is followed by the 4 RDATA bytes, MSB first.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (8 or more)
//   BUS_TIMEOUT   cycles to wait for GNT, and separately for RVALID
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx / tx            UART receive / transmit lines (idle high)
//   REQ, WE, BE, ADDR, WDATA   bus request and fields (outputs)
//   GNT, RVALID, RDATA         bus grant and response (inputs)
//
// Optional feature (compile-time macro UART_BRIDGE_FRAME_TIMEOUT_EN):
//   When this macro is defined, a gap of more than 16 bit-times inside a
//   partial frame aborts that frame and returns the FSM to CMD. When it is not
//   defined, a partial frame waits indefinitely for its remaining bytes.
// -----------------------------------------------------------------------------
module uart_bus_bridge #(
  parameter int CLKS_PER_BIT = 217,
  parameter int BUS_TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        REQ,
  output logic        WE,
  output logic [3:0]  BE,
  output logic [23:0] ADDR,
  output logic [31:0] WDATA,
  input  logic        GNT,
  input  logic        RVALID,
  input  logic [31:0] RDATA
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(BUS_TIMEOUT - 1);

  localparam logic [7:0] STAT_OK = 8'hA5;
  localparam logic [7:0] STAT_TO = 8'hEE;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_DATA, ST_BUS, ST_RSP, ST_TX_STAT, ST_TX_DATA
  } state_e;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic            rx_meta_q, rx_meta_d;
  logic            rx_sync_q, rx_sync_d;
  logic            rx_prev_q, rx_prev_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_byte_valid;
  logic            rx_frame_err;

  always_comb begin
    // NOTE: every variable gets a default first. Otherwise a branch that does
    // not assign it would infer a latch.
    rx_meta_d     = rx;
    rx_sync_d     = rx_meta_q;
    rx_prev_d     = rx_sync_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_valid = 1'b0;
    rx_frame_err  = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          // A line that is high again at mid-start was only a glitch.
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          // The byte is delivered at the stop-bit mid-sample. The FSM acts on
          // it in this same cycle.
          rx_state_d    = RX_IDLE;
          rx_byte_valid = rx_sync_q;
          rx_frame_err  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional inter-byte gap watchdog
  // ---------------------------------------------------------------------------
  logic frame_gap_expired;

`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
  localparam int            GW      = $clog2(16 * CLKS_PER_BIT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(16 * CLKS_PER_BIT);

  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  state_e        state_q;

  // Counts only while a frame is partially received and the receiver is idle.
  // That interval runs from one stop bit to the next start bit.
  always_comb begin
    gap_cnt_d = '0;
    if ((state_q == ST_ADDR || state_q == ST_DATA) && rx_state_q == RX_IDLE) begin
      gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
    end
    frame_gap_expired = (gap_cnt_q == GAP_MAX);
  end
`else
  state_e state_q;
  assign frame_gap_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM, bus master and transmitter
  // ---------------------------------------------------------------------------
  state_e        state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    status_q, status_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_last;
  logic          tx_load;
  logic [7:0]    tx_load_byte;
  logic          frame_abort;

  assign frame_abort = rx_frame_err | frame_gap_expired;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    status_d     = status_q;
    rdata_d      = rdata_q;
    req_d        = req_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_busy_d    = tx_busy_q;
    tx_last      = 1'b0;
    tx_load      = 1'b0;
    tx_load_byte = 8'h00;

    // The transmitter shifts one 10-bit frame: start, 8 data bits, stop.
    if (tx_busy_q) begin
      if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_bit_d  = '0;
          tx_last   = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_CMD: begin
        if (rx_byte_valid) begin
          we_d       = rx_shift_q[7];
          be_d       = rx_shift_q[3:0];
          byte_cnt_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (frame_abort) begin
          state_d = ST_CMD;
        end else if (rx_byte_valid) begin
          addr_d = {addr_q[15:0], rx_shift_q};
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = '0;
            if (we_q) begin
              state_d = ST_DATA;
            end else begin
              state_d  = ST_BUS;
              req_d    = 1'b1;
              to_cnt_d = '0;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (frame_abort) begin
          state_d = ST_CMD;
        end else if (rx_byte_valid) begin
          wdata_d = {wdata_q[23:0], rx_shift_q};
          if (byte_cnt_q == 2'd3) begin
            state_d  = ST_BUS;
            req_d    = 1'b1;
            to_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (GNT) begin
          req_d = 1'b0;
          if (RVALID) begin
            // A response in the grant cycle is taken at once. The status byte
            // is loaded straight into the transmitter, so the start bit
            // begins in the next cycle.
            rdata_d      = RDATA;
            status_d     = STAT_OK;
            state_d      = ST_TX_STAT;
            tx_load      = 1'b1;
            tx_load_byte = STAT_OK;
          end else begin
            state_d  = ST_RSP;
            to_cnt_d = '0;
          end
        end else if (to_cnt_q == TO_M1) begin
          req_d        = 1'b0;
          status_d     = STAT_TO;
          state_d      = ST_TX_STAT;
          tx_load      = 1'b1;
          tx_load_byte = STAT_TO;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_RSP: begin
        if (RVALID) begin
          rdata_d      = RDATA;
          status_d     = STAT_OK;
          state_d      = ST_TX_STAT;
          tx_load      = 1'b1;
          tx_load_byte = STAT_OK;
        end else if (to_cnt_q == TO_M1) begin
          status_d     = STAT_TO;
          state_d      = ST_TX_STAT;
          tx_load      = 1'b1;
          tx_load_byte = STAT_TO;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_TX_STAT: begin
        // The next byte loads on the last cycle of the current stop bit, so
        // bytes go out back-to-back. rdata_q shifts left by one byte for
        // each byte that is sent.
        if (tx_last) begin
          if (!we_q && status_q == STAT_OK) begin
            state_d      = ST_TX_DATA;
            byte_cnt_d   = '0;
            tx_load      = 1'b1;
            tx_load_byte = rdata_q[31:24];
            rdata_d      = {rdata_q[23:0], 8'h00};
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_TX_DATA: begin
        if (tx_last) begin
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_CMD;
          end else begin
            byte_cnt_d   = byte_cnt_q + 1'b1;
            tx_load      = 1'b1;
            tx_load_byte = rdata_q[31:24];
            rdata_d      = {rdata_q[23:0], 8'h00};
          end
        end
      end
      default: state_d = ST_CMD;
    endcase

    if (tx_load) begin
      tx_shift_d = {1'b1, tx_load_byte, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_busy_d  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only. That way every
  // flop samples the value from before the clock edge, whatever the statement
  // order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      state_q    <= ST_CMD;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign tx    = tx_shift_q[0];
  assign REQ   = req_q;
  assign WE    = we_q;
  assign BE    = be_q;
  assign ADDR  = addr_q;
  assign WDATA = wdata_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_bridge
//
// Directed bench for uart_bus_bridge. A host UART drives rx and decodes tx.
// A small register-file responder model answers on the REQ/GNT/RVALID bus,
// with a programmable grant delay and response delay.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

  localparam int CPB     = 8;
  localparam int RX_WAIT = 1500;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        tx;
  logic        REQ;
  logic        WE;
  logic [3:0]  BE;
  logic [23:0] ADDR;
  logic [31:0] WDATA;
  logic        GNT;
  logic        RVALID;
  logic [31:0] RDATA;

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .BUS_TIMEOUT(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .tx     (tx),
    .REQ    (REQ),
    .WE     (WE),
    .BE     (BE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .GNT    (GNT),
    .RVALID (RVALID),
    .RDATA  (RDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- register-file responder model ----------------
  logic [31:0] mem [16];
  int          gnt_delay;
  int          rv_delay;
  bit          gnt_block;
  int          txn_count;
  int          req_cycles;
  bit          fields_changed;
  int          rv_cyc;
  logic        we_seen;
  logic [3:0]  be_seen;
  logic [23:0] addr_seen;
  logic [31:0] wdata_seen;
  logic [31:0] rd_val;

  task automatic note_fields();
    if (WE !== we_seen || BE !== be_seen || ADDR !== addr_seen || WDATA !== wdata_seen)
      fields_changed = 1'b1;
  endtask

  initial begin
    GNT    = 1'b0;
    RVALID = 1'b0;
    RDATA  = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (REQ === 1'b1) begin
        txn_count++;
        req_cycles     = 1;
        fields_changed = 1'b0;
        we_seen        = WE;
        be_seen        = BE;
        addr_seen      = ADDR;
        wdata_seen     = WDATA;
        if (gnt_block) begin
          for (int i = 0; i < 5000 && REQ === 1'b1; i++) begin
            @(negedge clk);
            if (REQ === 1'b1) begin
              req_cycles++;
              note_fields();
            end
          end
        end else begin
          for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            if (REQ === 1'b1) req_cycles++;
            note_fields();
          end
          GNT    = 1'b1;
          rd_val = mem[ADDR[3:0]];
          if (WE) begin
            for (int b = 0; b < 4; b++)
              if (BE[b]) mem[ADDR[3:0]][8*b +: 8] = WDATA[8*b +: 8];
          end
          if (rv_delay == 0) begin
            RVALID = 1'b1;
            RDATA  = rd_val;
            rv_cyc = cyc;
          end
          @(negedge clk);
          GNT    = 1'b0;
          RVALID = 1'b0;
          RDATA  = 32'h0BAD_0BAD;
          if (rv_delay > 0) begin
            repeat (rv_delay - 1) @(negedge clk);
            RVALID = 1'b1;
            RDATA  = rd_val;
            rv_cyc = cyc;
            @(negedge clk);
            RVALID = 1'b0;
            RDATA  = 32'h0BAD_0BAD;
          end
        end
      end
    end
  end

  // ---------------- host UART ----------------
  logic [7:0] frame_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] resp_b [5];
  int         resp_c [5];
  int         resp_n;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
  endtask

  task automatic uart_recv(input int max_wait, output logic [7:0] b, output int start_c,
                           output bit ok);
    int n;
    n       = 0;
    b       = 8'h00;
    start_c = 0;
    ok      = 1'b0;
    while (tx !== 1'b0 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      start_c = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      ok = (tx === 1'b1);
    end
  endtask

  task automatic get_resp(input int n);
    logic [7:0] b;
    int         c;
    bit         ok;
    resp_n = 0;
    for (int i = 0; i < n; i++) begin
      uart_recv(RX_WAIT, b, c, ok);
      if (!ok) break;
      resp_b[i] = b;
      resp_c[i] = c;
      resp_n++;
    end
  endtask

  task automatic run_txn(input int n);
    fork
      send_frame();
      get_resp(n);
    join
  endtask

  task automatic check_resp(input string tag);
    check({tag, " byte count"}, 32'(resp_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < resp_n; i++)
      check($sformatf("%s byte%0d", tag, i), 32'(resp_b[i]), 32'(exp_q[i]));
  endtask

  task automatic check_silent(input string tag);
    logic [7:0] b;
    int         c;
    bit         ok;
    uart_recv(15 * CPB, b, c, ok);
    check(tag, 32'(tx === 1'b0 || ok), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int t0;

  initial begin
    checks    = 0;
    errors    = 0;
    rx        = 1'b1;
    rst_n     = 1'b0;
    gnt_delay = 0;
    rv_delay  = 0;
    gnt_block = 1'b0;
    txn_count = 0;
    foreach (mem[i]) mem[i] = 32'h0;

    repeat (5) @(negedge clk);
    check("reset tx",    32'(tx),    32'd1);
    check("reset REQ",   32'(REQ),   32'd0);
    check("reset WE",    32'(WE),    32'd0);
    check("reset BE",    32'(BE),    32'd0);
    check("reset ADDR",  32'(ADDR),  32'd0);
    check("reset WDATA", WDATA,      32'd0);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    // Full write, GNT and RVALID in the same cycle.
    frame_q = {8'h8F, 8'h00, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q   = {8'hA5};
    t0      = txn_count;
    run_txn(1);
    check_resp("write");
    check("write txn count",  32'(txn_count - t0), 32'd1);
    check("write WE",         32'(we_seen),    32'd1);
    check("write BE",         32'(be_seen),    32'hF);
    check("write ADDR",       32'(addr_seen),  32'h000005);
    check("write WDATA",      wdata_seen,      32'hDEADBEEF);
    check("write REQ cycles", 32'(req_cycles), 32'd1);
    check("write tx latency", 32'(resp_c[0] - rv_cyc), 32'd1);
    check_silent("write no data bytes");

    // Read back.
    frame_q = {8'h0F, 8'h00, 8'h00, 8'h05};
    exp_q   = {8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_txn(5);
    check_resp("read");
    check("read WE",      32'(we_seen),   32'd0);
    check("read ADDR",    32'(addr_seen), 32'h000005);
    check("read gap 0-1", 32'(resp_c[1] - resp_c[0]), 32'(10 * CPB));
    check("read gap 3-4", 32'(resp_c[4] - resp_c[3]), 32'(10 * CPB));

    // Partial write, BE = 0001, then read back.
    frame_q = {8'h81, 8'h00, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q   = {8'hA5};
    run_txn(1);
    check_resp("pwrite");
    check("pwrite BE",    32'(be_seen), 32'h1);
    check("pwrite WDATA", wdata_seen,   32'h11223344);
    frame_q = {8'h0F, 8'h00, 8'h00, 8'h05};
    exp_q   = {8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'h44};
    run_txn(5);
    check_resp("pread");

    // Reset in the middle of a frame.
    send_byte(8'h8F, 1'b1);
    send_byte(8'h00, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset REQ",  32'(REQ),  32'd0);
    check("midreset WE",   32'(WE),   32'd0);
    check("midreset BE",   32'(BE),   32'd0);
    check("midreset ADDR", 32'(ADDR), 32'd0);
    check("midreset tx",   32'(tx),   32'd1);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    // Delayed handshake: GNT 5 cycles late, RVALID a further 7 cycles.
    gnt_delay = 5;
    rv_delay  = 7;
    frame_q   = {8'h0F, 8'h00, 8'h00, 8'h05};
    exp_q     = {8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'h44};
    run_txn(5);
    check_resp("delayed");
    check("delayed REQ cycles",    32'(req_cycles),     32'd6);
    check("delayed fields stable", 32'(fields_changed), 32'd0);
    check("delayed tx latency",    32'(resp_c[0] - rv_cyc), 32'd1);
    gnt_delay = 0;
    rv_delay  = 0;

    // Timeout: GNT never arrives.
    gnt_block = 1'b1;
    frame_q   = {8'h0F, 8'h00, 8'h00, 8'h09};
    exp_q     = {8'hEE};
    run_txn(1);
    check_resp("timeout");
    check("timeout REQ cycles", 32'(req_cycles), 32'd15);
    check_silent("timeout no data bytes");
    gnt_block = 1'b0;

    // Framing error in mid-frame, then a fresh write command.
    send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b0);
    frame_q = {8'h8F, 8'h00, 8'h00, 8'h06, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    exp_q   = {8'hA5};
    t0      = txn_count;
    run_txn(1);
    check_resp("framing");
    check("framing txn count", 32'(txn_count - t0), 32'd1);
    check("framing WE",        32'(we_seen),   32'd1);
    check("framing ADDR",      32'(addr_seen), 32'h000006);
    check("framing WDATA",     wdata_seen,     32'hCAFEF00D);
    frame_q = {8'h0F, 8'h00, 8'h00, 8'h06};
    exp_q   = {8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_txn(5);
    check_resp("framing read");

`ifdef UART_BRIDGE_FRAME_TIMEOUT_EN
    // A 20-bit-time gap after the address bytes abandons the partial write.
    t0 = txn_count;
    send_byte(8'h8F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    repeat (20 * CPB) @(negedge clk);
    check("gap no REQ", 32'(txn_count - t0), 32'd0);
    frame_q = {8'h0F, 8'h00, 8'h00, 8'h05};
    exp_q   = {8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'h44};
    run_txn(5);
    check_resp("gap read");
    check("gap read WE", 32'(we_seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
